// File: rtl/bp_counter_table.sv
`default_nettype none
// ============================================================================
//  Module      : bp_counter_table
//  Description : Table of 2**IDX_W saturating branch-prediction counters with
//                separate predict/update ports and a saturating mispredict
//                counter. Optional gshare indexing via macro BP_GSHARE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_counter_table #(
    parameter int PC_W     = 32,
    parameter int IDX_W    = 4,
    parameter int CTR_W    = 2,
    parameter int INIT_VAL = 3,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_req,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [CTR_W-1:0]  pred_ctr,
    output logic [IDX_W-1:0]  pred_ghr,
    input  logic              upd_en,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic [IDX_W-1:0]  upd_ghr,
    input  logic              upd_taken,
    input  logic              upd_pred,
    output logic [STAT_W-1:0] mispred_cnt
);

    localparam int               C_DEPTH    = 2**IDX_W;
    localparam logic [CTR_W-1:0] C_CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] C_CTR_INIT = CTR_W'(INIT_VAL);

    logic [CTR_W-1:0]  ctr_q [C_DEPTH];
    logic [CTR_W-1:0]  ctr_d [C_DEPTH];
    logic [IDX_W-1:0]  hist;
    logic [IDX_W-1:0]  pred_idx;
    logic [IDX_W-1:0]  upd_idx;
    logic [CTR_W-1:0]  upd_cur;

    logic              pred_valid_q, pred_valid_d;
    logic              pred_taken_q, pred_taken_d;
    logic [CTR_W-1:0]  pred_ctr_q,   pred_ctr_d;
    logic [IDX_W-1:0]  pred_ghr_q,   pred_ghr_d;
    logic [STAT_W-1:0] mispred_q,    mispred_d;
    logic              w_unused;

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr_q, ghr_d;

    always_comb begin
        ghr_d = ghr_q;
        if (upd_en) ghr_d = {ghr_q[IDX_W-2:0], upd_taken};
    end

    always_ff @(posedge clk) begin
        if (rst) ghr_q <= '0;
        else     ghr_q <= ghr_d;
    end

    assign hist    = ghr_q;
    assign upd_idx = upd_pc[IDX_W+1:2] ^ upd_ghr;
    assign w_unused = ^{pred_pc, upd_pc};
`else
    assign hist    = '0;
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign w_unused = ^{pred_pc, upd_pc, upd_ghr};
`endif

    assign pred_idx = pred_pc[IDX_W+1:2] ^ hist;
    assign upd_cur  = ctr_q[upd_idx];

    // Only the addressed entry moves; saturate rather than wrap at both ends.
    always_comb begin
        for (int i = 0; i < C_DEPTH; i++) ctr_d[i] = ctr_q[i];
        if (upd_en) begin
            if (upd_taken) begin
                if (upd_cur != C_CTR_MAX) ctr_d[upd_idx] = upd_cur + CTR_W'(1);
            end else begin
                if (upd_cur != '0)        ctr_d[upd_idx] = upd_cur - CTR_W'(1);
            end
        end
    end

    // Prediction reads the registered table, so a same-cycle update is not visible.
    always_comb begin
        pred_valid_d = pred_req;
        pred_taken_d = pred_taken_q;
        pred_ctr_d   = pred_ctr_q;
        pred_ghr_d   = pred_ghr_q;
        if (pred_req) begin
            pred_ctr_d   = ctr_q[pred_idx];
            pred_taken_d = ctr_q[pred_idx][CTR_W-1];
            pred_ghr_d   = hist;
        end
    end

    always_comb begin
        mispred_d = mispred_q;
        if (upd_en && (upd_pred != upd_taken) && (mispred_q != {STAT_W{1'b1}}))
            mispred_d = mispred_q + STAT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C_DEPTH; i++) ctr_q[i] <= C_CTR_INIT;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_ctr_q   <= '0;
            pred_ghr_q   <= '0;
            mispred_q    <= '0;
        end else begin
            for (int i = 0; i < C_DEPTH; i++) ctr_q[i] <= ctr_d[i];
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_ctr_q   <= pred_ctr_d;
            pred_ghr_q   <= pred_ghr_d;
            mispred_q    <= mispred_d;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign pred_ctr    = pred_ctr_q;
    assign pred_ghr    = pred_ghr_q;
    assign mispred_cnt = mispred_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_counter_table.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bp_counter_table
//  Description : Directed and random checks of bp_counter_table against a
//                behavioural table model (STAT_W=2 to reach saturation).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_counter_table;

    localparam int C_IDX_W = 4;
    localparam int C_DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_req;
    logic [31:0] pred_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [1:0]  pred_ctr;
    logic [3:0]  pred_ghr;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic [3:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_pred;
    logic [1:0]  mispred_cnt;

    bp_counter_table #(
        .PC_W(32), .IDX_W(C_IDX_W), .CTR_W(2), .INIT_VAL(3), .STAT_W(2)
    ) dut (
        .clk(clk), .rst(rst),
        .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_ctr(pred_ctr), .pred_ghr(pred_ghr),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_pred(upd_pred),
        .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: plain integers, clamped arithmetic.
    int m_ctr [C_DEPTH];
    int m_mis;
    int m_ghr;
    int e_valid, e_taken, e_ctr, e_ghr;

    function automatic int f_idx(logic [31:0] pc, int h);
        return ((pc >> 2) % C_DEPTH) ^ h;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int h;
        int ui;
`ifdef BP_GSHARE_EN
        h = m_ghr;
`else
        h = 0;
`endif
        if (rst) begin
            for (int i = 0; i < C_DEPTH; i++) m_ctr[i] = 3;
            m_mis = 0; m_ghr = 0;
            e_valid = 0; e_taken = 0; e_ctr = 0; e_ghr = 0;
        end else begin
            e_valid = pred_req;
            if (pred_req) begin
                e_ctr   = m_ctr[f_idx(pred_pc, h)];
                e_taken = e_ctr / 2;
                e_ghr   = h;
            end
            if (upd_en) begin
`ifdef BP_GSHARE_EN
                ui = f_idx(upd_pc, int'(upd_ghr));
`else
                ui = f_idx(upd_pc, 0);
`endif
                if (upd_taken) m_ctr[ui] = (m_ctr[ui] + 1 > 3) ? 3 : m_ctr[ui] + 1;
                else           m_ctr[ui] = (m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1;
                if (upd_pred != upd_taken) m_mis = (m_mis + 1 > 3) ? 3 : m_mis + 1;
                m_ghr = ((m_ghr << 1) | int'(upd_taken)) % C_DEPTH;
            end
        end
        @(posedge clk);
        #1;
        chk("pred_valid",  {31'd0, pred_valid}, e_valid);
        chk("pred_taken",  {31'd0, pred_taken}, e_taken);
        chk("pred_ctr",    {30'd0, pred_ctr},   e_ctr);
        chk("pred_ghr",    {28'd0, pred_ghr},   e_ghr);
        chk("mispred_cnt", {30'd0, mispred_cnt}, m_mis);
    endtask

    task automatic drive(logic r, logic req, logic [31:0] ppc, logic en,
                         logic [31:0] upc, logic tk, logic pd);
        rst = r; pred_req = req; pred_pc = ppc;
        upd_en = en; upd_pc = upc; upd_taken = tk; upd_pred = pd;
        upd_ghr = e_ghr[3:0];
        tick();
    endtask

    task automatic pred(logic [31:0] pc);
        drive(1'b0, 1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic upd(logic [31:0] pc, logic tk, logic pd);
        drive(1'b0, 1'b0, 32'h0, 1'b1, pc, tk, pd);
    endtask

    initial begin
        int exp2 [8] = '{2, 1, 0, 0, 1, 2, 3, 3};
        e_ghr = 0;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Defaults after reset
        pred(32'h40);
        chk("t1_ctr", {30'd0, pred_ctr}, 3);
        chk("t1_taken", {31'd0, pred_taken}, 1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t1_single_valid", {31'd0, pred_valid}, 0);

        // Saturation at both ends (mispredict flags: 5 differ, 3 agree)
        for (int i = 0; i < 8; i++) begin
            upd(32'h40, (i >= 4), (i < 5) ? (i < 4) : (i >= 4));
            pred(32'h40);
`ifndef BP_GSHARE_EN
            chk("t2_sat", {30'd0, pred_ctr}, exp2[i]);
`endif
        end
        chk("t5_mispred_sat", {30'd0, mispred_cnt}, 3);

        // Isolation and aliasing
        for (int i = 0; i < 3; i++) upd(32'h44, 1'b0, 1'b0);
        pred(32'h48);
        pred(32'h84);
`ifndef BP_GSHARE_EN
        chk("t3_alias", {30'd0, pred_ctr}, 0);
`endif

        // Same-index predict and update: read-before-write
        drive(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 1'b0);
        pred(32'h40);

        // Back-to-back random traffic on a few aliasing PCs
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom)};
            b = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom)};
            drive(1'b0, 1'($urandom), a, 1'($urandom), b, 1'($urandom), 1'($urandom));
        end

        // Reset mid-run with a concurrent request, then every entry reads INIT_VAL
        upd(32'h40, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 1'b1);
        chk("t6_rst_valid", {31'd0, pred_valid}, 0);
        chk("t6_rst_mis", {30'd0, mispred_cnt}, 0);
        for (int i = 0; i < C_DEPTH; i++) begin
            pred(32'(i * 4));
            chk("t6_init", {30'd0, pred_ctr}, 3);
        end

        // History build-up taken, taken, not-taken
        upd(32'h0, 1'b1, 1'b1);
        upd(32'h0, 1'b1, 1'b1);
        upd(32'h0, 1'b0, 1'b0);
        pred(32'h40);
`ifdef BP_GSHARE_EN
        chk("t6_ghr", {28'd0, pred_ghr}, 32'h6);
`else
        chk("t6_ghr_off", {28'd0, pred_ghr}, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
